// File: rtl/gray_to_bin_if.sv
// gray_to_bin_if: valid-qualified Gray-code input and binary output bundle
// for gray_to_bin. The step_err/step_err_sticky signals exist only when
// GRAY_STEP_CHECK_EN is defined.
interface gray_to_bin_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic [WIDTH-1:0] bin_out;
`ifdef GRAY_STEP_CHECK_EN
    logic             step_err;
    logic             step_err_sticky;

    // Producer side: supplies codes and observes converted results
    modport master (
        output in_valid, gray_in,
        input  out_valid, bin_out, step_err, step_err_sticky
    );

    // Converter side
    modport slave (
        input  in_valid, gray_in,
        output out_valid, bin_out, step_err, step_err_sticky
    );
`else
    // Producer side: supplies codes and observes converted results
    modport master (
        output in_valid, gray_in,
        input  out_valid, bin_out
    );

    // Converter side
    modport slave (
        input  in_valid, gray_in,
        output out_valid, bin_out
    );
`endif
endinterface

// File: rtl/gray_to_bin.sv
// gray_to_bin: registered Gray-to-binary converter, one-cycle latency, one
// conversion per cycle, no backpressure.
// Optional feature macro: GRAY_STEP_CHECK_EN adds a unit-distance checker
// (step_err pulse aligned with out_valid, step_err_sticky held until reset).
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    gray_to_bin_if.slave bus
);

    logic [WIDTH-1:0] bin_next;

    // Each binary bit is the XOR of all Gray bits at or above its position;
    // a reduction per bit avoids a long combinational self-referencing chain.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_conv
            assign bin_next[gi] = ^bus.gray_in[WIDTH-1:gi];
        end
    endgenerate

    // Output register: capture the conversion on every accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bin_out   <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.bin_out <= bin_next;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] prev_code_reg;
    logic             first_sample_reg;
    logic [WIDTH-1:0] code_diff;
    logic             multi_bit;

    // More than one bit changed exactly when clearing the lowest set bit of
    // the difference still leaves something set (no popcount adder needed).
    assign code_diff = bus.gray_in ^ prev_code_reg;
    assign multi_bit = (code_diff & (code_diff - ONE)) != '0;

    // Previous-code tracking and step error flags; the first code after
    // reset has no predecessor and is never flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_code_reg       <= '0;
            first_sample_reg    <= 1'b1;
            bus.step_err        <= 1'b0;
            bus.step_err_sticky <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                prev_code_reg    <= bus.gray_in;
                first_sample_reg <= 1'b0;
                bus.step_err     <= multi_bit && !first_sample_reg;
                if (multi_bit && !first_sample_reg) begin
                    bus.step_err_sticky <= 1'b1;
                end
            end else begin
                bus.step_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_to_bin.sv
// tb_gray_to_bin: randomized and directed checks of gray_to_bin against a
// search-based reference (find b whose Gray encoding b ^ (b >> 1) equals g).
// Step checks are compiled in when GRAY_STEP_CHECK_EN is defined.
module tb_gray_to_bin;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    gray_to_bin_if #(.WIDTH(4)) bus4 ();
    gray_to_bin_if #(.WIDTH(8)) bus8 ();

    gray_to_bin #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    gray_to_bin #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    // Reference model state for the 4-bit instance
    logic [3:0] exp_bin;
    logic       exp_valid;
    logic       exp_err;
    logic       exp_sticky;
    logic [3:0] prev_g;
    logic       first;

    function automatic int ref_bin(input int g, input int w);
        for (int b = 0; b < (1 << w); b++) begin
            if (((b ^ (b >> 1)) & ((1 << w) - 1)) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_bin    = 4'd0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_sticky = 1'b0;
        prev_g     = 4'd0;
        first      = 1'b1;
    endtask

    // Drive one cycle on the 4-bit instance and advance the model
    task automatic apply(input logic v, input logic [3:0] g);
        bus4.in_valid = v;
        bus4.gray_in  = g;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            exp_bin = 4'(ref_bin(int'(g), 4));
            exp_err = !first && ($countones(g ^ prev_g) > 1);
            if (exp_err) exp_sticky = 1'b1;
            prev_g = g;
            first  = 1'b0;
        end else begin
            exp_err = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus4.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus4.in_valid = 1'b1;
        bus4.gray_in  = 4'b1111;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus4.bin_out !== 4'd0 || bus4.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d bin_out=%b out_valid=%b expected 0000/0", i, bus4.bin_out, bus4.out_valid);
            end
`ifdef GRAY_STEP_CHECK_EN
            checks++;
            if (bus4.step_err_sticky !== 1'b0 || bus4.step_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_err cyc=%0d step_err=%b sticky=%b expected 0/0", i, bus4.step_err, bus4.step_err_sticky);
            end
`endif
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release out_valid=%b expected 0", bus4.out_valid);
        end
        apply(1'b1, 4'b1111);
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.bin_out !== exp_bin) begin
            errors++;
            $display("FAIL reset_first bin_out=%b out_valid=%b expected %b/1", bus4.bin_out, bus4.out_valid, exp_bin);
        end
        $display("test_reset: first output bin_out=%b", bus4.bin_out);
    endtask

    task automatic test_sweep();
        logic [3:0] tbl_g [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1111};
        logic [3:0] tbl_b [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b0101, 4'b1111, 4'b1010};
        for (int g = 0; g < 16; g++) begin
            apply(1'b1, 4'(g));
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.bin_out !== exp_bin) begin
                errors++;
                $display("FAIL sweep g=%b bin_out=%b out_valid=%b expected %b/1", 4'(g), bus4.bin_out, bus4.out_valid, exp_bin);
            end
            for (int k = 0; k < 8; k++) begin
                if (tbl_g[k] == 4'(g)) begin
                    checks++;
                    if (bus4.bin_out !== tbl_b[k]) begin
                        errors++;
                        $display("FAIL sweep_table g=%b bin_out=%b expected %b", tbl_g[k], bus4.bin_out, tbl_b[k]);
                    end
                end
            end
            $display("sweep: gray_in=%b bin_out=%b", 4'(g), bus4.bin_out);
        end
    endtask

    task automatic test_hold();
        apply(1'b1, 4'b0110);
        checks++;
        if (bus4.bin_out !== 4'b0100) begin
            errors++;
            $display("FAIL hold_load bin_out=%b expected 0100", bus4.bin_out);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'b1001);
            checks++;
            if (bus4.bin_out !== 4'b0100 || bus4.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc=%0d bin_out=%b out_valid=%b expected 0100/0", i, bus4.bin_out, bus4.out_valid);
            end
        end
        $display("test_hold: bin_out=%b held", bus4.bin_out);
    endtask

`ifdef GRAY_STEP_CHECK_EN
    task automatic test_step_check();
        logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, seq[i]);
            checks++;
            if (bus4.step_err !== 1'b0 || bus4.step_err_sticky !== 1'b0) begin
                errors++;
                $display("FAIL step_legal g=%b step_err=%b sticky=%b expected 0/0", seq[i], bus4.step_err, bus4.step_err_sticky);
            end
        end
        apply(1'b1, 4'b0111);
        checks++;
        if (bus4.step_err !== 1'b1 || bus4.bin_out !== 4'b0101 || bus4.step_err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL step_two_bit step_err=%b bin_out=%b sticky=%b expected 1/0101/1", bus4.step_err, bus4.bin_out, bus4.step_err_sticky);
        end
        apply(1'b0, 4'b0111);
        checks++;
        if (bus4.step_err !== 1'b0 || bus4.step_err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL step_pulse step_err=%b sticky=%b expected 0/1", bus4.step_err, bus4.step_err_sticky);
        end
        $display("test_step_check: sticky=%b", bus4.step_err_sticky);
    endtask

    task automatic test_sticky_wrap();
        apply(1'b1, 4'b1000);
        checks++;
        if (bus4.step_err !== exp_err) begin
            errors++;
            $display("FAIL wrap_pre step_err=%b expected %b", bus4.step_err, exp_err);
        end
        apply(1'b1, 4'b0000);
        checks++;
        if (bus4.step_err !== 1'b0 || bus4.step_err_sticky !== 1'b1 || bus4.bin_out !== 4'b0000) begin
            errors++;
            $display("FAIL wrap step_err=%b sticky=%b bin_out=%b expected 0/1/0000", bus4.step_err, bus4.step_err_sticky, bus4.bin_out);
        end
        do_reset();
        checks++;
        if (bus4.step_err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear sticky=%b expected 0", bus4.step_err_sticky);
        end
        apply(1'b1, 4'b1111);
        checks++;
        if (bus4.step_err !== 1'b0 || bus4.bin_out !== 4'b1010) begin
            errors++;
            $display("FAIL first_after_reset step_err=%b bin_out=%b expected 0/1010", bus4.step_err, bus4.bin_out);
        end
        $display("test_sticky_wrap: sticky=%b", bus4.step_err_sticky);
    endtask
`endif

    task automatic test_random();
        logic       v;
        logic [3:0] g;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            g = 4'($urandom);
            if ($urandom_range(0, 1) == 1) g = prev_g ^ (4'b0001 << $urandom_range(0, 3));
            apply(v, g);
            checks++;
            if (bus4.out_valid !== exp_valid || bus4.bin_out !== exp_bin) begin
                errors++;
                $display("FAIL random i=%0d v=%b g=%b bin_out=%b out_valid=%b expected %b/%b", i, v, g, bus4.bin_out, bus4.out_valid, exp_bin, exp_valid);
            end
`ifdef GRAY_STEP_CHECK_EN
            checks++;
            if (bus4.step_err !== exp_err || bus4.step_err_sticky !== exp_sticky) begin
                errors++;
                $display("FAIL random_step i=%0d g=%b step_err=%b sticky=%b expected %b/%b", i, g, bus4.step_err, bus4.step_err_sticky, exp_err, exp_sticky);
            end
`endif
        end
        $display("test_random: 300 cycles, last bin_out=%b", bus4.bin_out);
    endtask

    task automatic test_width8();
        logic [7:0] g;
        logic [7:0] e;
        bus8.in_valid = 1'b1;
        bus8.gray_in  = 8'b10000000;
        @(posedge clk);
        #1;
        checks++;
        if (bus8.bin_out !== 8'b11111111 || bus8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL w8_a bin_out=%b out_valid=%b expected 11111111/1", bus8.bin_out, bus8.out_valid);
        end
        bus8.gray_in = 8'b11000000;
        @(posedge clk);
        #1;
        checks++;
        if (bus8.bin_out !== 8'b10000000) begin
            errors++;
            $display("FAIL w8_b bin_out=%b expected 10000000", bus8.bin_out);
        end
        for (int i = 0; i < 20; i++) begin
            g = 8'($urandom);
            e = 8'(ref_bin(int'(g), 8));
            bus8.gray_in = g;
            @(posedge clk);
            #1;
            checks++;
            if (bus8.bin_out !== e) begin
                errors++;
                $display("FAIL w8_rand g=%b bin_out=%b expected %b", g, bus8.bin_out, e);
            end
        end
        bus8.in_valid = 1'b0;
        $display("test_width8: last bin_out=%b", bus8.bin_out);
    endtask

    initial begin
        bus4.in_valid = 1'b0;
        bus4.gray_in  = 4'd0;
        bus8.in_valid = 1'b0;
        bus8.gray_in  = 8'd0;
        model_reset();
        #2;
        test_reset();
        test_sweep();
        test_hold();
`ifdef GRAY_STEP_CHECK_EN
        test_step_check();
        test_sticky_wrap();
`endif
        test_random();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_to_bin.md
# gray_to_bin

Registered, parameterizable Gray-code-to-binary converter with valid qualification. It sits wherever a reflected-binary code, such as a CDC-synchronized FIFO pointer or an encoder position, must be turned back into plain binary for arithmetic. An optional unit-distance checker flags successive valid codes that differ in more than one bit.

## Interface
Parameters:
- WIDTH, default 4: code width in bits; legal range 2..32.

Ports:
- clk  input  1: single clock; all state updates on its rising edge.
- rst_n  input  1: reset, asynchronous and active-low; deassertion is synchronous to clk.
- in_valid  input  1: gray_in is valid this cycle.
- gray_in  input  WIDTH: reflected-binary Gray code input.
- out_valid  output  1: bin_out updated this cycle (one-cycle pulse per accepted input).
- bin_out  output  WIDTH: converted binary value, registered.
- step_err  output  1: present only with GRAY_STEP_CHECK_EN; one-cycle pulse aligned with out_valid.
- step_err_sticky  output  1: present only with GRAY_STEP_CHECK_EN; set by any step_err, cleared only by reset.

## Operation
- Conversion rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0, i.e. b[i] = XOR of g[WIDTH-1:i].
- The conversion is computed combinationally from gray_in and captured into bin_out when in_valid = 1.
- When in_valid = 0, bin_out holds its last value and out_valid = 0.
- There is no backpressure. Every cycle with in_valid = 1 is accepted.
- Every input code is legal. X-free input always gives an X-free output.
- There is no state machine. Only two registers are datapath state: bin_out/out_valid, and the optional previous-code register.

## Timing
- Latency: 1 cycle. gray_in sampled at edge N appears on bin_out, with out_valid = 1, after edge N.
- Throughput: one conversion per cycle. Back-to-back valids produce back-to-back outputs.
- Reset values, asynchronous on rst_n low: bin_out = 0, out_valid = 0, step_err = 0, step_err_sticky = 0, previous-code register = 0, first-sample flag = 1.
- Reset asserted mid-stream: outputs clear immediately. The sample in flight is discarded.
- First valid after reset: no step check is performed (first-sample flag). The flag clears on that sample.

## Configuration
- Macro: GRAY_STEP_CHECK_EN.
- When defined:
  - The block keeps the last accepted gray_in.
  - On each subsequent valid, it computes popcount(gray_in XOR prev).
  - A popcount of 0 (repeat) or 1 is legal.
  - A popcount of 2 or more pulses step_err with the corresponding out_valid and sets step_err_sticky.
  - Wrap-around from code 1000 to code 0000 (WIDTH = 4) is a single-bit step and is legal.
- When undefined:
  - The step_err and step_err_sticky ports and the previous-code logic are removed.
  - Conversion behaviour and latency are identical.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 1 and gray_in = 1111. Required: bin_out = 0000, out_valid = 0, step_err_sticky = 0 throughout; the first output appears one cycle after release.
- Full sweep (WIDTH = 4): drive gray_in = 0000 through 1111 incrementing, one per cycle, in_valid = 1. Required, one cycle later:
  - 0000 -> 0000
  - 0001 -> 0001
  - 0010 -> 0011
  - 0011 -> 0010
  - 0100 -> 0111
  - 0111 -> 0101
  - 1000 -> 1111
  - 1111 -> 1010
  - out_valid = 1 every cycle.
- Hold: apply gray_in = 0110 valid, then drop in_valid and change gray_in to 1001 for 3 cycles. Required: bin_out stays 0100, out_valid = 0.
- Step check (macro on):
  - Sequence 0000, 0001, 0011, 0010: no step_err.
  - Then 0111 (two bits from 0010): step_err pulses for one cycle with bin_out = 0101, and step_err_sticky = 1.
- Sticky and wrap (macro on):
  - Sequence 1000, 0000: no new step_err.
  - step_err_sticky stays 1 until rst_n = 0, then reads 0.
  - The first valid after reset, 1111, raises no step_err.
- Width scaling: WIDTH = 8, gray_in = 10000000 -> bin_out = 11111111; gray_in = 11000000 -> bin_out = 10000000.
